// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
//
// Owns the single write port of the register file. Two result sources share
// it:
//   - the in-order pipeline writeback (priority, never backpressured)
//   - a multicycle unit (mul/div) whose results are buffered in a small
//     circular FIFO behind a valid/ready handshake.
// A per-register scoreboard (busy_vec) marks destinations with a multicycle
// result still outstanding so decode can stall on RAW/WAW hazards.
//
// Optional feature (compile-time macro): WB_FIFO_BYPASS_EN
//   When defined, a multicycle result arriving while the FIFO is empty and no
//   valid pipeline write is present goes straight to the register file in the
//   same cycle instead of being enqueued.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   p_wen/p_waddr/p_wdata      pipeline writeback (zero-latency pass-through)
//   m_valid/m_ready            multicycle result handshake
//   m_waddr/m_wdata            multicycle result destination and data
//   m_issue/m_issue_addr       decode issued a multicycle op to this register
//   busy_vec                   one bit per register, set while outstanding
//   rf_wen/rf_waddr/rf_wdata   register file write port
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_COUNT      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      p_wen,
    input  logic [REG_ADDR_WIDTH-1:0] p_waddr,
    input  logic [XLEN-1:0]           p_wdata,

    input  logic                      m_valid,
    output logic                      m_ready,
    input  logic [REG_ADDR_WIDTH-1:0] m_waddr,
    input  logic [XLEN-1:0]           m_wdata,

    input  logic                      m_issue,
    input  logic [REG_ADDR_WIDTH-1:0] m_issue_addr,
    output logic [REG_COUNT-1:0]      busy_vec,

    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [XLEN-1:0]           rf_wdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [XLEN-1:0]           data;
    } wb_entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wb_entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [REG_COUNT-1:0]  busy_q;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic                      p_act;      // pipeline write to a real register
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      m_take;     // handshake completes
    logic                      m_live;     // accepted and not addressed to r0
    logic                      bypass;
    logic                      push;
    logic                      pop;
    wb_entry_t                 head;
    wb_entry_t                 m_entry;
    logic                      clr_en;     // a multicycle write hits the port
    logic [REG_ADDR_WIDTH-1:0] clr_addr;
    logic [REG_COUNT-1:0]      busy_nxt;

    always_comb begin
        p_act      = p_wen && (p_waddr != '0);
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        // Ready depends only on the current count: a pop this cycle does not
        // open a slot for this cycle's push.
        m_ready    = !reset && !fifo_full;
        m_take     = m_valid && m_ready;
        // r0 results complete the handshake but are otherwise discarded.
        m_live     = m_take && (m_waddr != '0);
`ifdef WB_FIFO_BYPASS_EN
        bypass     = m_live && fifo_empty && !p_act;
`else
        bypass     = 1'b0;
`endif
        push       = m_live && !bypass;
        pop        = !reset && !p_act && !fifo_empty;
        head       = fifo_mem[rd_ptr];
        m_entry    = '{addr: m_waddr, data: m_wdata};
    end

    // ------------------------------------------------------------------
    // Write-port mux: pipeline > FIFO head > bypassed result > idle.
    // Idle drives zeros so the port is quiet; reset forces idle
    // asynchronously regardless of inputs.
    // ------------------------------------------------------------------
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        clr_en   = 1'b0;
        clr_addr = '0;
        if (reset) begin
            rf_wen = 1'b0;
        end else if (p_act) begin
            rf_wen   = 1'b1;
            rf_waddr = p_waddr;
            rf_wdata = p_wdata;
        end else if (!fifo_empty) begin
            rf_wen   = 1'b1;
            rf_waddr = head.addr;
            rf_wdata = head.data;
            clr_en   = 1'b1;
            clr_addr = head.addr;
        end else if (bypass) begin
            rf_wen   = 1'b1;
            rf_waddr = m_waddr;
            rf_wdata = m_wdata;
            clr_en   = 1'b1;
            clr_addr = m_waddr;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state. The clear is applied first so that an issue
    // to the same register in the same cycle (a new op reusing the
    // destination just retired) leaves the bit set.
    // ------------------------------------------------------------------
    always_comb begin
        busy_nxt = busy_q;
        for (int r = 1; r < REG_COUNT; r++) begin
            if (clr_en && (clr_addr == REG_ADDR_WIDTH'(r)))
                busy_nxt[r] = 1'b0;
            if (m_issue && (m_issue_addr == REG_ADDR_WIDTH'(r)))
                busy_nxt[r] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    assign busy_vec = busy_q;

    // ------------------------------------------------------------------
    // FIFO pointers, occupancy and scoreboard registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy_q <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            busy_q <= busy_nxt;
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= m_entry;
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

    localparam int XLEN  = 32;
    localparam int RC    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
`ifdef WB_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            p_wen;
    logic [AW-1:0]   p_waddr;
    logic [XLEN-1:0] p_wdata;
    logic            m_valid;
    logic            m_ready;
    logic [AW-1:0]   m_waddr;
    logic [XLEN-1:0] m_wdata;
    logic            m_issue;
    logic [AW-1:0]   m_issue_addr;
    logic [RC-1:0]   busy_vec;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    wb_write_arbiter #(
        .XLEN(XLEN), .REG_COUNT(RC), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .p_wen(p_wen), .p_waddr(p_waddr), .p_wdata(p_wdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_issue(m_issue), .m_issue_addr(m_issue_addr), .busy_vec(busy_vec),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of pending results and a set of busy regs.
    // Evaluated on the falling edge, when inputs are stable for the cycle.
    // ------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];
    logic [RC-1:0]   mbusy;
    logic            e_wen;
    logic [AW-1:0]   e_addr;
    logic [XLEN-1:0] e_data;
    logic            e_rdy;
    bit              p_act, m_acc, from_mc, byp_now;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            mbusy = '0;
            check("rst_wen",  64'(rf_wen),   64'h0);
            check("rst_rdy",  64'(m_ready),  64'h0);
            check("rst_busy", 64'(busy_vec), 64'h0);
        end else begin
            p_act   = p_wen && (p_waddr != 0);
            e_rdy   = (q.size() < DEPTH);
            m_acc   = m_valid && e_rdy;
            e_wen   = 1'b0;
            e_addr  = '0;
            e_data  = '0;
            from_mc = 1'b0;
            byp_now = 1'b0;
            if (p_act) begin
                e_wen = 1'b1; e_addr = p_waddr; e_data = p_wdata;
            end else if (q.size() > 0) begin
                e_wen = 1'b1; e_addr = q[0].addr; e_data = q[0].data; from_mc = 1'b1;
            end else if (BYP && m_acc && (m_waddr != 0)) begin
                e_wen = 1'b1; e_addr = m_waddr; e_data = m_wdata; from_mc = 1'b1;
                byp_now = 1'b1;
            end
            check("cyc_wen",   64'(rf_wen),   64'(e_wen));
            check("cyc_waddr", 64'(rf_waddr), 64'(e_addr));
            check("cyc_wdata", 64'(rf_wdata), 64'(e_data));
            check("cyc_ready", 64'(m_ready),  64'(e_rdy));
            check("cyc_busy",  64'(busy_vec), 64'(mbusy));

            if (p_act)
                assert (!mbusy[p_waddr])
                    else $error("stimulus: pipeline write to busy r%0d", p_waddr);
            if (m_issue && (m_issue_addr != 0))
                assert (!mbusy[m_issue_addr] || (from_mc && e_addr == m_issue_addr))
                    else $error("stimulus: issue to busy r%0d", m_issue_addr);

            if (from_mc) mbusy[e_addr] = 1'b0;
            if (!p_act && q.size() > 0) void'(q.pop_front());
            if (m_acc && (m_waddr != 0) && !byp_now) q.push_back('{m_waddr, m_wdata});
            if (m_issue && (m_issue_addr != 0)) mbusy[m_issue_addr] = 1'b1;
            mbusy[0] = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        p_wen = 0; p_waddr = '0; p_wdata = '0;
        m_valid = 0; m_waddr = '0; m_wdata = '0;
        m_issue = 0; m_issue_addr = '0;
        repeat (3) tick();
        check("in_reset_rdy", 64'(m_ready), 64'h0);
        check("in_reset_wen", 64'(rf_wen),  64'h0);
        reset = 1'b0;
        #1;
        check("post_rst_rdy",  64'(m_ready),  64'h1);
        check("post_rst_wen",  64'(rf_wen),   64'h0);
        check("post_rst_busy", 64'(busy_vec), 64'h0);

        // Pipeline priority, zero latency
        tick();
        p_wen = 1; p_waddr = AW'(5); p_wdata = 32'hDEADBEEF;
        #1;
        check("pipe_wen",   64'(rf_wen),   64'h1);
        check("pipe_waddr", 64'(rf_waddr), 64'h5);
        check("pipe_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        check("pipe_busy",  64'(busy_vec), 64'h0);
        tick();
        p_wen = 0; p_waddr = '0; p_wdata = '0;

        // Scoreboard with a queued (or bypassed) write
        m_issue = 1; m_issue_addr = AW'(7);
        tick();
        m_issue = 0; m_issue_addr = '0;
        check("sb_set", 64'(busy_vec), 64'h80);
        tick();
        tick();
        m_valid = 1; m_waddr = AW'(7); m_wdata = 32'h12345678;
        #1;
        check("sb_acc_wen",  64'(rf_wen),   64'(BYP));
        check("sb_acc_busy", 64'(busy_vec), 64'h80);
        tick();
        m_valid = 0; m_waddr = '0; m_wdata = '0;
        #1;
        check("sb_wr_wen",   64'(rf_wen),   64'(!BYP));
        check("sb_wr_waddr", 64'(rf_waddr), BYP ? 64'h0 : 64'h7);
        check("sb_wr_busy",  64'(busy_vec), BYP ? 64'h0 : 64'h80);
        tick();
        check("sb_clr_busy", 64'(busy_vec), 64'h0);
        check("sb_clr_wen",  64'(rf_wen),   64'h0);

        // Full FIFO under sustained pipeline writes, then in-order drain
        p_wen = 1; p_waddr = AW'(3); p_wdata = 32'h33330000;
        for (int i = 0; i < 4; i++) begin
            m_valid = 1; m_waddr = AW'(8 + i); m_wdata = XLEN'(32'hA0000000 + i);
            #1;
            check("fill_rdy", 64'(m_ready), 64'h1);
            tick();
        end
        m_waddr = AW'(12); m_wdata = 32'hA0000004;
        #1;
        check("full_rdy",   64'(m_ready),  64'h0);
        check("full_waddr", 64'(rf_waddr), 64'h3);
        tick();
        check("stall_rdy", 64'(m_ready), 64'h0);
        p_wen = 0; p_waddr = '0; p_wdata = '0;
        #1;
        check("drain0_waddr", 64'(rf_waddr), 64'h8);
        check("drain0_wdata", 64'(rf_wdata), 64'hA0000000);
        check("drain0_rdy",   64'(m_ready),  64'h0);
        tick();
        check("drain1_waddr", 64'(rf_waddr), 64'h9);
        check("drain1_rdy",   64'(m_ready),  64'h1);
        tick();
        m_valid = 0; m_waddr = '0; m_wdata = '0;
        for (int j = 2; j < 5; j++) begin
            #1;
            check("drain_waddr", 64'(rf_waddr), 64'(8 + j));
            tick();
        end
        check("drain_done_wen", 64'(rf_wen), 64'h0);

        // Address 0 from both sources
        m_valid = 1; m_waddr = '0; m_wdata = 32'hFFFF0000;
        p_wen = 1; p_waddr = '0; p_wdata = 32'hEEEE0000;
        #1;
        check("r0_wen", 64'(rf_wen),  64'h0);
        check("r0_rdy", 64'(m_ready), 64'h1);
        tick();
        m_valid = 0; p_wen = 0; p_wdata = '0; m_wdata = '0;
        #1;
        check("r0_after_wen", 64'(rf_wen), 64'h0);

        // Set/clear collision on r9
        m_issue = 1; m_issue_addr = AW'(9);
        tick();
        m_issue = 0;
        check("col_set", 64'(busy_vec), 64'h200);
        m_valid = 1; m_waddr = AW'(9); m_wdata = 32'h00000099;
        m_issue = BYP; m_issue_addr = AW'(9);
        tick();
        m_valid = 0; m_waddr = '0; m_wdata = '0;
        m_issue = !BYP;
        tick();
        m_issue = 0; m_issue_addr = '0;
        check("col_busy", 64'(busy_vec), 64'h200);

        // Back-to-back stream: simultaneous push/pop, pipeline slot mid-way
        for (int i = 0; i < 6; i++) begin
            m_valid = 1; m_waddr = AW'(12 + i); m_wdata = XLEN'(32'hC0000000 + i);
            p_wen = (i == 3); p_waddr = AW'(4); p_wdata = 32'h44444444;
            tick();
        end
        m_valid = 0; m_waddr = '0; m_wdata = '0;
        p_wen = 0; p_waddr = '0; p_wdata = '0;
        repeat (4) tick();
        check("stream_idle", 64'(rf_wen), 64'h0);

        // Reset with three entries queued and r8..r10 busy
        m_issue = 1; m_issue_addr = AW'(8);
        tick();
        m_issue_addr = AW'(10);
        tick();
        m_issue = 0; m_issue_addr = '0;
        p_wen = 1; p_waddr = AW'(3); p_wdata = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            m_valid = 1; m_waddr = AW'(8 + i); m_wdata = XLEN'(32'hB0000000 + i);
            tick();
        end
        m_valid = 0; m_waddr = '0; m_wdata = '0;
        #1;
        check("pre_rst_busy", 64'(busy_vec), 64'h700);
        check("pre_rst_rdy",  64'(m_ready),  64'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_wen",  64'(rf_wen),   64'h0);
        check("mid_rst_busy", 64'(busy_vec), 64'h0);
        check("mid_rst_rdy",  64'(m_ready),  64'h0);
        tick();
        reset = 1'b0;
        p_wen = 0; p_waddr = '0; p_wdata = '0;
        #1;
        check("rel_rdy", 64'(m_ready), 64'h1);
        check("rel_wen", 64'(rf_wen),  64'h0);
        tick();
        check("rel_empty_wen", 64'(rf_wen), 64'h0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
